// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter and sequencer sharing one main-memory port between ICACHE and DCACHE.
// Grants in IDLE, strobes memory in ISSUE, waits out busy flags, pulses ready in RESP.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     icache_addr,
    input  logic                  icache_req,
    output logic [DATA_W-1:0]     icache_rdata,
    output logic                  icache_ready,
    input  logic [ADDR_W-1:0]     dcache_addr,
    input  logic                  dcache_req,
    input  logic                  dcache_we,
    input  logic [DATA_W-1:0]     dcache_wdata,
    input  logic [DATA_W/8-1:0]   dcache_wmask,
    output logic [DATA_W-1:0]     dcache_rdata,
    output logic                  dcache_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    output logic                  mem_rstrb,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_rbusy,
    input  logic                  mem_wbusy,
    output logic                  arb_busy,
    output logic                  arb_grant
);

    localparam int unsigned MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic                we_q, we_d;
    logic [MASK_W-1:0]   wstrb_q, wstrb_d;
    logic                rstrb_q, rstrb_d;
    logic [DATA_W-1:0]   resp_q, resp_d;
    logic                irdy_q, irdy_d;
    logic                drdy_q, drdy_d;
    logic                busy_q, busy_d;
    logic                pick_dcache_c;

    // On a tie, the side that did not hold the last grant wins.
    assign pick_dcache_c = dcache_req && (!icache_req || !grant_q);

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            rstrb_q <= 1'b0;
            resp_q  <= '0;
            irdy_q  <= 1'b0;
            drdy_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
            rstrb_q <= rstrb_d;
            resp_q  <= resp_d;
            irdy_q  <= irdy_d;
            drdy_q  <= drdy_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and next-output logic; strobes and ready are computed one
    // cycle ahead so they line up with the ISSUE and RESP states.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        we_d    = we_q;
        resp_d  = resp_q;
        wstrb_d = '0;
        rstrb_d = 1'b0;
        irdy_d  = 1'b0;
        drdy_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (icache_req || dcache_req) begin
                    grant_d = pick_dcache_c;
                    state_d = S_ISSUE;
                    if (pick_dcache_c) begin
                        addr_d  = dcache_addr;
                        we_d    = dcache_we;
                        wdata_d = dcache_we ? dcache_wdata : '0;
                        mask_d  = dcache_we ? dcache_wmask : '0;
                    end else begin
                        addr_d  = icache_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        mask_d  = '0;
                    end
                    if (!we_d) begin
                        rstrb_d = 1'b1;
                    end else begin
                        wstrb_d = mask_d;
                    end
                end
            end
            S_ISSUE: begin
                if (we_q && (mask_q == '0)) begin
                    state_d = S_RESP;
                    irdy_d  = !grant_q;
                    drdy_d  = grant_q;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!mem_rbusy && !mem_wbusy) begin
                    resp_d  = mem_rdata;
                    state_d = S_RESP;
                    irdy_d  = !grant_q;
                    drdy_d  = grant_q;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign icache_rdata = resp_q;
    assign dcache_rdata = resp_q;
    assign icache_ready = irdy_q;
    assign dcache_ready = drdy_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_wmask    = wstrb_q;
    assign mem_rstrb    = rstrb_q;
    assign arb_busy     = busy_q;
    assign arb_grant    = grant_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: memory responder with programmable busy time,
// word-level reference memory, per-scenario tasks with randomized transactions.
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] icache_addr = '0;
    logic        icache_req = 1'b0;
    logic [31:0] icache_rdata;
    logic        icache_ready;
    logic [31:0] dcache_addr = '0;
    logic        dcache_req = 1'b0;
    logic        dcache_we = 1'b0;
    logic [31:0] dcache_wdata = '0;
    logic [3:0]  dcache_wmask = '0;
    logic [31:0] dcache_rdata;
    logic        dcache_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;
    logic        arb_busy;
    logic        arb_grant;

    int errors = 0;
    int checks = 0;

    // Memory seen through the DUT's strobes, and the reference the bench expects.
    logic [31:0] mem_arr [8];
    logic [31:0] ref_mem [8];

    int          busy_len = 0;
    int          busy_cnt = 0;
    logic        busy_is_w = 1'b0;
    int          rstrb_cnt = 0;
    int          wstrb_cnt = 0;
    int          both_cnt = 0;
    logic [31:0] strb_addr = '0;
    logic [31:0] strb_wdata = '0;
    logic [3:0]  strb_mask = '0;
    logic [31:0] wtmp;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .icache_addr(icache_addr), .icache_req(icache_req),
        .icache_rdata(icache_rdata), .icache_ready(icache_ready),
        .dcache_addr(dcache_addr), .dcache_req(dcache_req), .dcache_we(dcache_we),
        .dcache_wdata(dcache_wdata), .dcache_wmask(dcache_wmask),
        .dcache_rdata(dcache_rdata), .dcache_ready(dcache_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
        .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy),
        .arb_busy(arb_busy), .arb_grant(arb_grant)
    );

    assign mem_rbusy = (busy_cnt > 0) && !busy_is_w;
    assign mem_wbusy = (busy_cnt > 0) && busy_is_w;
    // Garbage while busy so an early capture of read data is visible.
    assign mem_rdata = (mem_rbusy || mem_wbusy) ? 32'hBAD0_BAD0 : mem_arr[mem_addr[4:2]];

    // Memory responder: busy rises the cycle after a strobe and lasts busy_len cycles.
    always @(posedge clk) begin
        if (reset) begin
            busy_cnt <= 0;
        end else begin
            if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
            if (mem_rstrb && (mem_wmask != 4'h0)) both_cnt <= both_cnt + 1;
            if (mem_rstrb) begin
                rstrb_cnt <= rstrb_cnt + 1;
                strb_addr <= mem_addr;
                busy_cnt  <= busy_len;
                busy_is_w <= 1'b0;
            end
            if (mem_wmask != 4'h0) begin
                wstrb_cnt  <= wstrb_cnt + 1;
                strb_addr  <= mem_addr;
                strb_wdata <= mem_wdata;
                strb_mask  <= mem_wmask;
                busy_cnt   <= busy_len;
                busy_is_w  <= 1'b1;
                wtmp = mem_arr[mem_addr[4:2]];
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) wtmp[8*b +: 8] = mem_wdata[8*b +: 8];
                mem_arr[mem_addr[4:2]] <= wtmp;
            end
        end
    end

    // One transaction from one side; latency counted in cycles with req high, first cycle = 1.
    task automatic do_single(input bit side, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] mask,
                             input int nbusy, input string nm);
        int          exp_lat;
        int          cnt;
        int          r0;
        int          w0;
        int          other_hi;
        bit          got;
        bit          is_wr;
        bit          zero_mask;
        logic [31:0] exp_rd;
        logic [31:0] got_rd;
        logic        got_grant;
        logic        got_busy;
        is_wr     = side && we;
        zero_mask = is_wr && (mask == 4'h0);
        exp_lat   = zero_mask ? 3 : 4 + nbusy;
        exp_rd    = ref_mem[addr[4:2]];
        if (is_wr)
            for (int b = 0; b < 4; b++)
                if (mask[b]) ref_mem[addr[4:2]][8*b +: 8] = wdata[8*b +: 8];
        busy_len = nbusy;
        r0 = rstrb_cnt;
        w0 = wstrb_cnt;
        other_hi = 0;
        got = 1'b0;
        cnt = 0;
        got_rd = '0;
        got_grant = 1'b0;
        got_busy = 1'b0;
        @(posedge clk); #1;
        if (side) begin
            dcache_addr = addr; dcache_we = we; dcache_wdata = wdata; dcache_wmask = mask;
            dcache_req = 1'b1;
        end else begin
            icache_addr = addr;
            icache_req = 1'b1;
        end
        while (!got && cnt < 60) begin
            @(negedge clk);
            cnt++;
            if (side ? icache_ready : dcache_ready) other_hi++;
            if (side ? dcache_ready : icache_ready) begin
                got = 1'b1;
                got_rd = side ? dcache_rdata : icache_rdata;
                got_grant = arb_grant;
                got_busy = arb_busy;
            end
        end
        @(posedge clk); #1;
        icache_req = 1'b0;
        dcache_req = 1'b0;

        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no ready after %0d cycles", nm, cnt);
        end else begin
            checks++;
            if (cnt !== exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", nm, cnt, exp_lat);
            end
            checks++;
            if (got_grant !== side) begin
                errors++;
                $display("FAIL %s arb_grant: got %0b expected %0b", nm, got_grant, side);
            end
            checks++;
            if (got_busy !== 1'b1) begin
                errors++;
                $display("FAIL %s arb_busy in RESP: got %0b expected 1", nm, got_busy);
            end
            if (!is_wr) begin
                checks++;
                if (got_rd !== exp_rd) begin
                    errors++;
                    $display("FAIL %s rdata: got %08h expected %08h", nm, got_rd, exp_rd);
                end
            end
        end
        checks++;
        if (other_hi !== 0) begin
            errors++;
            $display("FAIL %s other ready: got %0d pulses expected 0", nm, other_hi);
        end
        checks++;
        if ((rstrb_cnt - r0) !== (is_wr ? 0 : 1)) begin
            errors++;
            $display("FAIL %s rstrb count: got %0d expected %0d", nm, rstrb_cnt - r0, is_wr ? 0 : 1);
        end
        checks++;
        if ((wstrb_cnt - w0) !== ((is_wr && !zero_mask) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s wstrb count: got %0d expected %0d", nm, wstrb_cnt - w0,
                     (is_wr && !zero_mask) ? 1 : 0);
        end
        if (!zero_mask) begin
            checks++;
            if (strb_addr !== addr) begin
                errors++;
                $display("FAIL %s mem_addr at strobe: got %08h expected %08h", nm, strb_addr, addr);
            end
        end
        if (is_wr && !zero_mask) begin
            checks++;
            if (strb_wdata !== wdata || strb_mask !== mask) begin
                errors++;
                $display("FAIL %s write payload: got %08h/%01h expected %08h/%01h",
                         nm, strb_wdata, strb_mask, wdata, mask);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({icache_ready, dcache_ready, mem_rstrb, arb_busy} !== 4'b0) begin
            errors++;
            $display("FAIL reset flags: got %04b expected 0000",
                     {icache_ready, dcache_ready, mem_rstrb, arb_busy});
        end
        checks++;
        if (arb_grant !== 1'b1) begin
            errors++;
            $display("FAIL reset arb_grant: got %0b expected 1", arb_grant);
        end
        checks++;
        if (mem_wmask !== 4'h0) begin
            errors++;
            $display("FAIL reset mem_wmask: got %01h expected 0", mem_wmask);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset mem_addr/wdata: got %08h/%08h expected 0/0", mem_addr, mem_wdata);
        end
        checks++;
        if (icache_rdata !== 32'h0 || dcache_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset rdata: got %08h/%08h expected 0/0", icache_rdata, dcache_rdata);
        end
    endtask

    // Both sides hold req; grants must alternate I, D, I, D every 4 cycles.
    task automatic test_round_robin();
        int   n;
        int   cnt;
        int   r0;
        int   both_rdy;
        int   at [4];
        bit   who [4];
        logic gnt [4];
        busy_len = 0;
        r0 = rstrb_cnt;
        n = 0;
        cnt = 0;
        both_rdy = 0;
        @(posedge clk); #1;
        icache_addr = 32'h104;
        dcache_addr = 32'h108;
        dcache_we = 1'b0;
        icache_req = 1'b1;
        dcache_req = 1'b1;
        while (n < 4 && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (icache_ready && dcache_ready) both_rdy++;
            else if (icache_ready || dcache_ready) begin
                who[n] = dcache_ready;
                at[n] = cnt;
                gnt[n] = arb_grant;
                n++;
            end
        end
        @(posedge clk); #1;
        icache_req = 1'b0;
        dcache_req = 1'b0;
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL rr timeout: got %0d completions expected 4", n);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (who[k] !== k[0] || gnt[k] !== k[0]) begin
                    errors++;
                    $display("FAIL rr order %0d: got side %0b grant %0b expected %0b",
                             k, who[k], gnt[k], k[0]);
                end
                checks++;
                if (at[k] !== 4 * (k + 1)) begin
                    errors++;
                    $display("FAIL rr ready cycle %0d: got %0d expected %0d", k, at[k], 4 * (k + 1));
                end
            end
        end
        checks++;
        if (both_rdy !== 0 || (rstrb_cnt - r0) !== 4) begin
            errors++;
            $display("FAIL rr strobes/readies: got %0d strobes %0d double readies expected 4/0",
                     rstrb_cnt - r0, both_rdy);
        end
    endtask

    task automatic test_icache_read();
        do_single(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, "icache_read");
    endtask

    task automatic test_dcache_write_wait();
        do_single(1'b1, 1'b1, 32'h200, 32'h1234_5678, 4'hF, 3, "dcache_write");
        do_single(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 2, "dcache_readback");
    endtask

    task automatic test_zero_mask();
        do_single(1'b1, 1'b1, 32'h20C, 32'hFFFF_FFFF, 4'h0, 2, "zero_mask");
        do_single(1'b1, 1'b0, 32'h20C, 32'h0, 4'h0, 0, "zero_mask_readback");
    endtask

    task automatic test_random();
        bit          side;
        bit          we;
        logic [31:0] addr;
        for (int i = 0; i < 40; i++) begin
            side = 1'($urandom_range(0, 1));
            we   = side ? 1'($urandom_range(0, 1)) : 1'b0;
            addr = 32'h300 + 32'(4 * $urandom_range(0, 7));
            do_single(side, we, addr, $urandom, 4'($urandom_range(0, 15)),
                      int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_reset_wait();
        int cnt;
        int r0;
        int rdy;
        busy_len = 10;
        r0 = rstrb_cnt;
        cnt = 0;
        @(posedge clk); #1;
        icache_addr = 32'h104;
        icache_req = 1'b1;
        while (rstrb_cnt == r0 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        checks++;
        if (mem_rbusy !== 1'b1 || arb_busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait setup: got rbusy %0b busy %0b expected 1/1", mem_rbusy, arb_busy);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        icache_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (arb_busy !== 1'b0 || mem_rstrb !== 1'b0 || mem_wmask !== 4'h0) begin
            errors++;
            $display("FAIL rst_wait state: got busy %0b rstrb %0b wmask %01h expected 0/0/0",
                     arb_busy, mem_rstrb, mem_wmask);
        end
        rdy = 0;
        repeat (8) begin
            if (icache_ready || dcache_ready) rdy++;
            @(negedge clk);
        end
        checks++;
        if (rdy !== 0) begin
            errors++;
            $display("FAIL rst_wait ready: got %0d pulses expected 0", rdy);
        end
        do_single(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1, "after_reset");
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[0] = 32'hDEAD_BEEF;
        ref_mem[0] = 32'hDEAD_BEEF;
        test_reset();
        test_round_robin();
        test_icache_read();
        test_dcache_write_wait();
        test_zero_mask();
        test_random();
        test_reset_wait();
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL strobe overlap: got %0d cycles with both strobes expected 0", both_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
